// File: rtl/pixel_feeder.sv
// Pixel feeder: walks a frame in row-major order, fetching each pixel from the
// image memory and presenting it with its coordinates and the frame's mask
// offsets to the masking stage under a tx/ready handshake.
module pixel_feeder #(
    parameter int unsigned IMG_ROWS = 320,
    parameter int unsigned IMG_COLS = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  i_offset_in,
    input  logic [7:0]  j_offset_in,
    output logic        mem_rd_en,
    output logic [16:0] mem_addr,
    input  logic [11:0] mem_rdata,
    output logic [11:0] pixel,
    output logic [8:0]  i_p,
    output logic [7:0]  j_p,
    output logic [8:0]  i_offset,
    output logic [7:0]  j_offset,
    output logic        tx,
    input  logic        ready,
    output logic        busy,
    output logic        done
);

    localparam int unsigned ROW_W  = 9;
    localparam int unsigned COL_W  = 8;
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned PIX_W  = 12;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [ROW_W-1:0]    i_nxt;
    logic [COL_W-1:0]    j_nxt;
    logic [ROW_W-1:0]    i_offset_nxt;
    logic [COL_W-1:0]    j_offset_nxt;
    logic [PIX_W-1:0]    pixel_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;

    // Next state, counters, offsets, captured pixel and fetch address
    always_comb begin
        state_nxt    = state;
        i_nxt        = i_p;
        j_nxt        = j_p;
        i_offset_nxt = i_offset;
        j_offset_nxt = j_offset;
        pixel_nxt    = pixel;
        mem_addr_nxt = mem_addr;

        case (state)
            S_IDLE: begin
                if (start) begin
                    i_offset_nxt = i_offset_in;
                    j_offset_nxt = j_offset_in;
                    i_nxt        = '0;
                    j_nxt        = '0;
                    state_nxt    = S_FETCH;
                end
            end
            S_FETCH: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                pixel_nxt = mem_rdata;
                state_nxt = S_PRESENT;
            end
            S_PRESENT: begin
                if (ready) begin
                    if (j_p != LAST_COL) begin
                        j_nxt     = j_p + COL_W'(1);
                        state_nxt = S_FETCH;
                    end else if (i_p != LAST_ROW) begin
                        j_nxt     = '0;
                        i_nxt     = i_p + ROW_W'(1);
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Address is formed from the coordinates the upcoming FETCH will use
        if (state_nxt == S_FETCH) begin
            mem_addr_nxt = ADDR_W'(i_nxt) * ADDR_W'(IMG_COLS) + ADDR_W'(j_nxt);
        end
    end

    // State and registered outputs; strobes are decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            i_p       <= '0;
            j_p       <= '0;
            i_offset  <= '0;
            j_offset  <= '0;
            pixel     <= '0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            tx        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            i_p       <= i_nxt;
            j_p       <= j_nxt;
            i_offset  <= i_offset_nxt;
            j_offset  <= j_offset_nxt;
            pixel     <= pixel_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_rd_en <= (state_nxt == S_FETCH);
            tx        <= (state_nxt == S_PRESENT);
            busy      <= (state_nxt == S_FETCH) || (state_nxt == S_WAIT) ||
                         (state_nxt == S_PRESENT);
            done      <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_pixel_feeder.sv
// Directed bench for pixel_feeder on a 2x3 frame; memory word at a = 12'h100+a.
module tb_pixel_feeder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [8:0]  i_offset_in;
    logic [7:0]  j_offset_in;
    logic        mem_rd_en;
    logic [16:0] mem_addr;
    logic [11:0] mem_rdata;
    logic [11:0] pixel;
    logic [8:0]  i_p;
    logic [7:0]  j_p;
    logic [8:0]  i_offset;
    logic [7:0]  j_offset;
    logic        tx;
    logic        ready;
    logic        busy;
    logic        done;

    int tests;
    int fails;
    int busy_cnt;
    int rd_cnt;
    logic [31:0] last_addr;

    pixel_feeder #(.IMG_ROWS(2), .IMG_COLS(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .i_offset_in(i_offset_in),
        .j_offset_in(j_offset_in),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .pixel      (pixel),
        .i_p        (i_p),
        .j_p        (j_p),
        .i_offset   (i_offset),
        .j_offset   (j_offset),
        .tx         (tx),
        .ready      (ready),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Image memory: one-cycle read latency
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= 12'h100 + 12'(mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and tally strobes seen there
    task automatic step();
        @(negedge clk);
        if (busy === 1'b1) busy_cnt++;
        if (mem_rd_en === 1'b1) begin
            rd_cnt++;
            last_addr = 32'(mem_addr);
        end
    endtask

    task automatic wait_tx(input int bound);
        int n;
        n = 0;
        while (tx !== 1'b1 && n < bound) begin
            step();
            n++;
        end
        check("tx_timeout", 32'(tx), 32'd1);
    endtask

    task automatic expect_pixel(input int k, input logic [8:0] io, input logic [7:0] jo);
        wait_tx(20);
        check("i_p", 32'(i_p), 32'(k / 3));
        check("j_p", 32'(j_p), 32'(k % 3));
        check("pixel", 32'(pixel), 32'(12'h100 + 12'(k)));
        check("fetch_addr", last_addr, 32'(k));
        check("i_offset", 32'(i_offset), 32'(io));
        check("j_offset", 32'(j_offset), 32'(jo));
    endtask

    task automatic start_frame(input logic [8:0] io, input logic [7:0] jo);
        start       = 1'b1;
        i_offset_in = io;
        j_offset_in = jo;
        busy_cnt    = 0;
        step();
        start       = 1'b0;
        i_offset_in = 9'd0;
        j_offset_in = 8'd0;
    endtask

    task automatic check_done_pulse();
        check("done_high", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        step();
        check("done_low", 32'(done), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pixel"}, 32'(pixel), 32'd0);
        check({tag, "_i_p"}, 32'(i_p), 32'd0);
        check({tag, "_j_p"}, 32'(j_p), 32'd0);
        check({tag, "_i_off"}, 32'(i_offset), 32'd0);
        check({tag, "_j_off"}, 32'(j_offset), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
        check({tag, "_tx"}, 32'(tx), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int rd_mark;
        tests       = 0;
        fails       = 0;
        busy_cnt    = 0;
        rd_cnt      = 0;
        last_addr   = 32'hffff_ffff;
        rst         = 1'b1;
        start       = 1'b0;
        ready       = 1'b0;
        i_offset_in = 9'd0;
        j_offset_in = 8'd0;

        // Reset state
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // Full frame, ready tied high
        ready = 1'b1;
        start_frame(9'd1, 8'd2);
        for (int k = 0; k < 6; k++) begin
            expect_pixel(k, 9'd1, 8'd2);
            step();
        end
        check_done_pulse();
        check("busy_cycles", 32'(busy_cnt), 32'd18);

        // Backpressure at pixel (0,1)
        step();
        start_frame(9'd3, 8'd4);
        expect_pixel(0, 9'd3, 8'd4);
        step();
        ready = 1'b0;
        expect_pixel(1, 9'd3, 8'd4);
        rd_mark = rd_cnt;
        for (int c = 0; c < 5; c++) begin
            check("stall_tx", 32'(tx), 32'd1);
            check("stall_pixel", 32'(pixel), 32'h101);
            check("stall_i_p", 32'(i_p), 32'd0);
            check("stall_j_p", 32'(j_p), 32'd1);
            if (c < 4) step();
        end
        check("stall_no_rd", 32'(rd_cnt), 32'(rd_mark));
        ready = 1'b1;
        step();
        for (int k = 2; k < 6; k++) begin
            expect_pixel(k, 9'd3, 8'd4);
            step();
        end
        check_done_pulse();

        // Start pulsed mid-frame is ignored
        step();
        start_frame(9'd1, 8'd2);
        expect_pixel(0, 9'd1, 8'd2);
        step();
        start       = 1'b1;
        i_offset_in = 9'd7;
        j_offset_in = 8'd5;
        step();
        start       = 1'b0;
        for (int k = 1; k < 6; k++) begin
            expect_pixel(k, 9'd1, 8'd2);
            step();
        end
        check_done_pulse();
        step();
        step();
        check("idle_after_frame", 32'(busy), 32'd0);

        // Reset while presenting (1,0), then a fresh frame
        start_frame(9'd2, 8'd1);
        for (int k = 0; k < 3; k++) begin
            expect_pixel(k, 9'd2, 8'd1);
            step();
        end
        expect_pixel(3, 9'd2, 8'd1);
        rst = 1'b1;
        step();
        check_all_zero("midrst");
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check("no_done_after_rst", 32'(done), 32'd0);
        end
        start_frame(9'd1, 8'd2);
        for (int k = 0; k < 6; k++) begin
            expect_pixel(k, 9'd1, 8'd2);
            step();
        end
        check_done_pulse();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
